// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier that borrows the shared ALU adder for one add per step.
// Optional build macro MUL_SEQ_EARLY_EXIT_EN: finish early with a barrel shift once the multiplier runs out of ones.
module alu_mul_seq #(
  parameter int         WIDTH       = 32,
  parameter int         CNT_W       = 6,
  parameter logic [3:0] ALU_ADD_CTL = 4'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             alu_req,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0]   prod_lo_q, prod_lo_d;
  logic               carry;
  logic               unused_lo_lsb;

  // The ALU has no carry-out; a wrapped sum is smaller than either addend.
  assign carry         = (alu_out < hi_q);
  assign unused_lo_lsb = lo_q[0];

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign prod_hi = prod_hi_q;
  assign prod_lo = prod_lo_q;
  assign alu_req = busy;
  assign alu_ctl = busy ? ALU_ADD_CTL : 4'd0;
  assign alu_a   = busy ? hi_q : '0;
  assign alu_b   = (busy && mplier_q[0]) ? mcand_q : '0;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  logic [CNT_W:0] shamt;
  assign shamt = (CNT_W + 1)'(WIDTH) - {1'b0, cnt_q};
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          mcand_d  = op_a;
          mplier_d = op_b;
          hi_d     = '0;
          lo_d     = op_b;
          cnt_d    = '0;
        end
      end
      RUN: begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
        // Remaining multiplier bits are all zero: only the final alignment shift is left.
        if (mplier_q == '0) begin
          {hi_d, lo_d} = {hi_q, lo_q} >> shamt;
          state_d      = DONE;
        end else
`endif
        begin
          {hi_d, lo_d} = {carry, alu_out, lo_q[WIDTH-1:1]};
          mplier_d     = mplier_q >> 1;
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
        end
        if (state_d == DONE) begin
          prod_hi_d = hi_d;
          prod_lo_d = lo_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed scenarios plus random operands against a 64-bit multiply model.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done, alu_req;
  logic [31:0] prod_hi, prod_lo, alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Behavioural shared ALU: add only.
  assign alu_out = alu_a + alu_b;

  alu_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
    .alu_req(alu_req), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out)
  );

  // Cycles from the start edge to the done cycle.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    int m = -1;
    int run;
    for (int i = 0; i < 32; i++) if (b[i]) m = i;
    run = (m < 0) ? 1 : ((m + 2 > 32) ? 32 : m + 2);
    return run + 1;
`else
    return 33;
`endif
  endfunction

  // Pulse start with the operands, then watch until done (bounded).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                       output int nbusy, output int ctl_bad, output logic [63:0] p);
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom;
    lat = -1; nbusy = 0; ctl_bad = 0; p = '0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        p = {prod_hi, prod_lo};
        break;
      end
      if (busy) nbusy++;
      if (alu_req !== busy) ctl_bad++;
      if (busy && alu_ctl !== 4'd0) ctl_bad++;
      @(negedge clk);
    end
    @(negedge clk);
    if (lat > 0 && done !== 1'b0) ctl_bad++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, alu_req, alu_ctl, prod_hi, prod_lo, alu_a, alu_b} !== '0) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b req=%b ctl=%h prod=%h_%h a=%h b=%h required all zero",
               busy, done, alu_req, alu_ctl, prod_hi, prod_lo, alu_a, alu_b);
    end
    rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_op(input string name, input logic [31:0] a, input logic [31:0] b);
    int lat, nbusy, cbad;
    logic [63:0] p, exp_p;
    exp_p = 64'(a) * 64'(b);
    do_op(a, b, lat, nbusy, cbad, p);
    n_cmp++;
    if (lat != exp_lat(b) || nbusy != exp_lat(b) - 1) begin
      n_bad++;
      $display("FAIL %s latency: done_at=%0d busy_cycles=%0d required %0d/%0d", name, lat, nbusy,
               exp_lat(b), exp_lat(b) - 1);
    end
    n_cmp++;
    if (p !== exp_p) begin
      n_bad++;
      $display("FAIL %s product: got %h required %h", name, p, exp_p);
    end
    n_cmp++;
    if (cbad != 0) begin
      n_bad++;
      $display("FAIL %s control: %0d bad req/ctl/done cycles, required 0", name, cbad);
    end
    $display("op %s: %h * %h = %h done_at=%0d", name, a, b, p, lat);
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    int l = exp_lat(32'd6);
    logic [63:0] p = '0;
    @(negedge clk);
    op_a = 32'd7; op_b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= l + 10; i++) begin
      if (done) begin ndone++; p = {prod_hi, prod_lo}; end
      if (i == 4 || i == l) begin op_a = 32'd2; op_b = 32'd2; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (ndone != 1 || p !== 64'd42) begin
      n_bad++;
      $display("FAIL ignore_start: dones=%0d product=%0d required 1 and 42", ndone, p);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_start idle: busy=%b required 0", busy);
    end
    $display("op ignore_start: dones=%0d product=%0d", ndone, p);
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    op_a = 32'd7; op_b = 32'h8000_0009; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, alu_req, prod_hi, prod_lo} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_run: busy=%b done=%b req=%b prod=%h_%h required all zero",
               busy, done, alu_req, prod_hi, prod_lo);
    end
    $display("reset mid-run checked");
    test_op("after_reset", 32'd3, 32'd4);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int k = 0; k < 1000; k++) begin
      a = $urandom;
      b = $urandom;
      if (k % 2 == 1) b = b >> $urandom_range(0, 31);
      test_op("random", a, b);
    end
  endtask

  initial begin
    test_reset();
    test_op("basic_3x5", 32'd3, 32'd5);
    test_op("carry_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_ignore_start();
    test_reset_mid_run();
    test_op("zero_a", 32'd0, 32'hDEAD_BEEF);
    test_op("b_msb", 32'h1234_5678, 32'h8000_0000);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    test_op("early_b0", 32'd9, 32'd0);
    test_op("early_b1", 32'd9, 32'd1);
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
